count_display_driver: RTL and testbench

- Consumes the n-bit count held by the count register and drives a multiplexed, common-anode 7-segment display.
- Converts the binary count to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Latches the finished digits and time-multiplexes them across DIGITS anodes at a divided scan rate.
- Sits directly downstream of the register. The register's enable/load strobe drives load_i.

---
 rtl/count_display_if.sv | 22 ++
 rtl/count_display_driver.sv | 178 +++++++++++++++++
 tb/tb_count_display_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/count_display_if.sv
// Handshake and display bundle between the count register and count_display_driver.
interface count_display_if #(
   parameter int n      = 8,
   parameter int DIGITS = 3
);
   logic                  load_i;
   logic [n-1:0]          data_i;
   logic [4*DIGITS-1:0]   bcd_o;
   logic                  busy_o;
   logic [DIGITS-1:0]     an_o;
   logic [6:0]            seg_o;

   modport master (
      output load_i, data_i,
      input  bcd_o, busy_o, an_o, seg_o
   );

   modport slave (
      input  load_i, data_i,
      output bcd_o, busy_o, an_o, seg_o
   );
endinterface

// File: rtl/count_display_driver.sv
// Binary count -> BCD (serial double-dabble) -> multiplexed common-anode 7-segment scan.
// Optional leading-zero blanking is enabled by defining COUNT_DISPLAY_BLANK_EN.
module count_display_driver #(
   parameter int n        = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset,
   count_display_if.slave   bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(n + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   function automatic logic [BW-1:0] f_dabble_adj(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [6:0] f_seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   state_t          r_state, w_state_nxt;
   logic [n-1:0]    r_shift, w_shift_nxt;
   logic [BW-1:0]   r_scratch, w_scratch_nxt;
   logic [n-1:0]    r_hold, w_hold_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_pending, w_pending_nxt;
   logic [BW-1:0]   r_bcd, w_bcd_nxt;
   logic [BW-1:0]   w_adj;

   logic [PW-1:0]     r_presc, w_presc_nxt;
   logic [IW-1:0]     r_idx, w_idx_nxt;
   logic [DIGITS-1:0] r_an, w_an_nxt;
   logic [6:0]        r_seg, w_seg_nxt;
   logic [3:0]        w_nib;
   logic [DIGITS-1:0] w_blank;
   logic              w_lead;
   logic              w_wrap;

   assign w_adj = f_dabble_adj(r_scratch);

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_scratch_nxt = r_scratch;
      w_hold_nxt    = r_hold;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      w_bcd_nxt     = r_bcd;
      case (r_state)
         S_IDLE: begin
            if (bus.load_i) begin
               w_shift_nxt   = bus.data_i;
               w_scratch_nxt = '0;
               w_cnt_nxt     = CW'(n);
               w_state_nxt   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_scratch_nxt = (w_adj << 1) | {{(BW-1){1'b0}}, r_shift[n-1]};
            w_shift_nxt   = r_shift << 1;
            w_cnt_nxt     = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            if (bus.load_i) begin
               w_hold_nxt    = bus.data_i;
               w_pending_nxt = 1'b1;
            end
         end
         S_DONE: begin
            w_bcd_nxt = r_scratch;
            // A load arriving in DONE itself is newest, so it beats the held value.
            if (bus.load_i || r_pending) begin
               w_shift_nxt   = bus.load_i ? bus.data_i : r_hold;
               w_scratch_nxt = '0;
               w_cnt_nxt     = CW'(n);
               w_pending_nxt = 1'b0;
               w_state_nxt   = S_SHIFT;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_bcd     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
         r_bcd     <= w_bcd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_shift   <= w_shift_nxt;
      r_scratch <= w_scratch_nxt;
      r_hold    <= w_hold_nxt;
   end

   always_comb begin
      w_wrap      = (r_presc == PW'(SCAN_DIV - 1));
      w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);
      w_idx_nxt   = r_idx;
      if (w_wrap) w_idx_nxt = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
   end

   // Anode and segment registers are both driven from the next index so they switch together.
   always_comb begin
      w_nib    = 4'd0;
      w_an_nxt = '1;
      w_blank  = '0;
      w_lead   = 1'b1;
`ifdef COUNT_DISPLAY_BLANK_EN
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_lead     = w_lead & (r_bcd[4*i +: 4] == 4'd0);
         w_blank[i] = w_lead && (i > 0);
      end
`endif
      w_seg_nxt = 7'b1111111;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_idx_nxt == IW'(i)) begin
            w_nib       = r_bcd[4*i +: 4];
            w_an_nxt[i] = 1'b0;
            w_seg_nxt   = w_blank[i] ? 7'b1111111 : f_seg7(r_bcd[4*i +: 4]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_an    <= {{(DIGITS-1){1'b1}}, 1'b0};
         r_seg   <= 7'b1000000;
      end else begin
         r_presc <= w_presc_nxt;
         r_idx   <= w_idx_nxt;
         r_an    <= w_an_nxt;
         r_seg   <= w_seg_nxt;
      end
   end

   assign bus.bcd_o  = r_bcd;
   assign bus.busy_o = (r_state != S_IDLE);
   assign bus.an_o   = r_an;
   assign bus.seg_o  = r_seg;

   logic w_unused;
   assign w_unused = ^w_nib;
endmodule

// File: tb/tb_count_display_driver.sv
// Directed/randomized bench for count_display_driver against a decimal-arithmetic model.
module tb_count_display_driver;
   localparam int N    = 8;
   localparam int DIG  = 3;
   localparam int SDIV = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   k = 0;
   int   cur_val = 0;
   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

   count_display_if #(.n(N), .DIGITS(DIG)) bus ();

   count_display_driver #(.n(N), .DIGITS(DIG), .SCAN_DIV(SDIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; the scan position follows from this alone.
   always @(posedge clk or posedge reset) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   function automatic logic [31:0] model_bcd(input int v);
      logic [31:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < DIG; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int pow10(input int e);
      int p;
      p = 1;
      for (int i = 0; i < e; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [31:0] model_seg(input int v, input int idx);
      int d;
      bit blank;
      d = (v / pow10(idx)) % 10;
      blank = 1'b0;
`ifdef COUNT_DISPLAY_BLANK_EN
      blank = (idx > 0) && (v < pow10(idx));
`endif
      return blank ? 32'h7F : {25'd0, seg_tab[d]};
   endfunction

   function automatic logic [31:0] model_an(input int idx);
      logic [31:0] a;
      a = '0;
      for (int i = 0; i < DIG; i++) a[i] = (i != idx);
      return a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_bcd"},  32'(bus.bcd_o),  32'h000);
      check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
      check({tag, "_an"},   32'(bus.an_o),   32'b110);
      check({tag, "_seg"},  32'(bus.seg_o),  32'b1000000);
   endtask

   // Load v1 at edge 0, optionally v2 at edge e2 and v3 at edge e3 (later loads win).
   task automatic run_seq(input int v1, input int e2, input int v2, input int e3, input int v3);
      int  prev, fin, last;
      bit  second;
      prev   = cur_val;
      second = (e2 >= 0);
      fin    = (e3 >= 0) ? v3 : (second ? v2 : v1);
      last   = second ? 2*N + 2 : N + 1;
      for (int e = 0; e <= last; e++) begin
         bus.load_i = (e == 0) || (e == e2) || (e == e3);
         if (e == 0)       bus.data_i = N'(v1);
         else if (e == e3) bus.data_i = N'(v3);
         else if (e == e2) bus.data_i = N'(v2);
         else              bus.data_i = N'($urandom);
         tick();
         bus.load_i = 1'b0;
         check("busy", 32'(bus.busy_o), (e <= (second ? 2*N + 1 : N)) ? 32'd1 : 32'd0);
         if (e < N + 1)                 check("bcd_hold", 32'(bus.bcd_o), model_bcd(prev));
         else if (second && e < 2*N + 2) check("bcd_first", 32'(bus.bcd_o), model_bcd(v1));
         else                            check("bcd_final", 32'(bus.bcd_o), model_bcd(fin));
      end
      cur_val = fin;
      tick();
   endtask

   task automatic scan_run(input int cycles);
      int idx;
      for (int c = 0; c < cycles; c++) begin
         idx = (k / SDIV) % DIG;
         check("scan_an",  32'(bus.an_o),  model_an(idx));
         check("scan_seg", 32'(bus.seg_o), model_seg(cur_val, idx));
         tick();
      end
   endtask

   initial begin
      int v, e2;
      bus.load_i = 1'b0;
      bus.data_i = '0;
      #1 reset = 1'b1;
      tick();
      check_reset_state("rst");
      reset = 1'b0;
      scan_run(3);

      run_seq(255, -1, 0, -1, 0);
      run_seq(7, 3, 42, 5, 99);
      run_seq(int'($urandom_range(0, 255)), N + 1, int'($urandom_range(0, 255)), -1, 0);
      run_seq(int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 255)), -1, 0);
      for (int r = 0; r < 4; r++) begin
         v  = int'($urandom_range(0, 255));
         e2 = int'($urandom_range(1, N + 1));
         if (r % 2 == 0) run_seq(v, -1, 0, -1, 0);
         else            run_seq(v, e2, int'($urandom_range(0, 255)), -1, 0);
      end
      run_seq(0, -1, 0, -1, 0);

      run_seq(123, -1, 0, -1, 0);
      scan_run(2 * DIG * SDIV + 3);
      run_seq(5, -1, 0, -1, 0);
      scan_run(DIG * SDIV + 1);
      run_seq(0, -1, 0, -1, 0);
      scan_run(DIG * SDIV + 1);
      run_seq(40, -1, 0, -1, 0);
      scan_run(DIG * SDIV + 1);
      run_seq(int'($urandom_range(0, 255)), -1, 0, -1, 0);
      scan_run(DIG * SDIV + 1);

      // Abort mid-conversion with a pending value queued.
      bus.load_i = 1'b1; bus.data_i = N'(200);
      tick();
      bus.data_i = N'(77);
      tick();
      bus.load_i = 1'b0;
      tick();
      reset = 1'b1;
      #1 check_reset_state("rst_mid");
      tick();
      check_reset_state("rst_hold");
      reset = 1'b0;
      cur_val = 0;
      for (int c = 0; c < 2*N + 4; c++) begin
         tick();
         check("post_rst_busy", 32'(bus.busy_o), 32'd0);
         check("post_rst_bcd",  32'(bus.bcd_o),  32'h000);
      end
      scan_run(DIG * SDIV);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
